// File: rtl/async_sr_conditioner.sv
// async_sr_conditioner: synchronises and debounces two push buttons and drives
// clean, mutually exclusive registered S/R pulses into the srgate latch.
module async_sr_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_LEN       = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic set_async,
    input  logic reset_async,
    output logic S,
    output logic R,
    output logic set_db,
    output logic reset_db,
    output logic busy,
    output logic conflict
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PLAST = PW'(PULSE_LEN - 1);

    typedef enum logic [1:0] {IDLE, SET_PULSE, RST_PULSE, HOLDOFF} state_t;

    state_t state, state_n;
    logic [PW-1:0] pcnt, pcnt_n;
    logic [1:0] raw, db, rise;
    logic conflict_n;

    assign raw = {reset_async, set_async};

    // Channel 0 is set, channel 1 is reset.
    generate
        for (genvar i = 0; i < 2; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] chain;
            logic [DW-1:0] cnt;
            logic lvl, lvl_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    chain <= '0;
                    cnt   <= '0;
                    lvl   <= 1'b0;
                    lvl_q <= 1'b0;
                end else begin
                    chain <= {chain[SYNC_STAGES-2:0], raw[i]};
                    lvl_q <= lvl;
                    if (chain[SYNC_STAGES-1] == lvl) begin
                        cnt <= '0;
                    end else if (cnt == DLAST) begin
                        cnt <= '0;
                        lvl <= ~lvl;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
            assign db[i]   = lvl;
            assign rise[i] = lvl & ~lvl_q;
        end
    endgenerate

    assign set_db   = db[0];
    assign reset_db = db[1];
    assign busy     = state != IDLE;

    always_comb begin
        state_n    = state;
        pcnt_n     = '0;
        conflict_n = 1'b0;
        case (state)
            IDLE: begin
                if ((rise[0] | rise[1]) & db[0] & db[1]) begin
                    state_n    = HOLDOFF;
                    conflict_n = 1'b1;
                end else if (rise[0] & ~db[1]) begin
                    state_n = SET_PULSE;
                end else if (rise[1] & ~db[0]) begin
                    state_n = RST_PULSE;
                end
            end
            SET_PULSE, RST_PULSE: begin
                pcnt_n  = pcnt == PLAST ? '0 : pcnt + 1'b1;
                state_n = pcnt == PLAST ? IDLE : state;
            end
            HOLDOFF: state_n = (~db[0] & ~db[1]) ? IDLE : HOLDOFF;
            default: state_n = IDLE;
        endcase
    end

    // S/R come straight from flops decoded off the next state, so they cannot glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pcnt     <= '0;
            S        <= 1'b0;
            R        <= 1'b0;
            conflict <= 1'b0;
        end else begin
            state    <= state_n;
            pcnt     <= pcnt_n;
            S        <= state_n == SET_PULSE;
            R        <= state_n == RST_PULSE;
            conflict <= conflict_n;
        end
    end
endmodule

// File: tb/tb_async_sr_conditioner.sv
// tb_async_sr_conditioner: directed scenarios plus random button activity, every
// cycle compared against a sample-history reference model.
module tb_async_sr_conditioner;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int PL   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_async = 1'b0;
    logic reset_async = 1'b0;
    logic S, R, set_db, reset_db, busy, conflict;

    int n_checks = 0;
    int n_fail = 0;
    int s_cnt, r_cnt, c_cnt, first_s;
    bit rs, rr;

    bit hist[2][$];
    bit m_db[2];
    bit m_dbq[2];
    int m_left;
    bit m_is_set, m_hold, m_conf;

    async_sr_conditioner #(
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .PULSE_LEN(PL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .set_async(set_async),
        .reset_async(reset_async),
        .S(S),
        .R(R),
        .set_db(set_db),
        .reset_db(reset_db),
        .busy(busy),
        .conflict(conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit samp(input int c, input int idx);
        return idx < 0 ? 1'b0 : hist[c][idx];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            hist[c].delete();
            m_db[c]  = 1'b0;
            m_dbq[c] = 1'b0;
        end
        m_left = 0;
        m_is_set = 1'b0;
        m_hold = 1'b0;
        m_conf = 1'b0;
    endtask

    // A level is accepted once the last DEB synchronised samples all disagree with it.
    task automatic model_edge(input bit s, input bit r);
        bit nd[2];
        bit rise[2];
        bit all;
        int k;
        k = hist[0].size();
        hist[0].push_back(s);
        hist[1].push_back(r);
        for (int c = 0; c < 2; c++) begin
            rise[c] = m_db[c] & ~m_dbq[c];
            all = 1'b1;
            for (int j = 0; j < DEB; j++)
                if (samp(c, k - SYNC - j) == m_db[c]) all = 1'b0;
            nd[c] = all ? ~m_db[c] : m_db[c];
        end
        m_conf = 1'b0;
        if (m_left > 0) m_left--;
        else if (m_hold) begin
            if (!m_db[0] && !m_db[1]) m_hold = 1'b0;
        end else if ((rise[0] || rise[1]) && m_db[0] && m_db[1]) begin
            m_hold = 1'b1;
            m_conf = 1'b1;
        end else if (rise[0] && !m_db[1]) begin
            m_left = PL;
            m_is_set = 1'b1;
        end else if (rise[1] && !m_db[0]) begin
            m_left = PL;
            m_is_set = 1'b0;
        end
        for (int c = 0; c < 2; c++) begin
            m_dbq[c] = m_db[c];
            m_db[c]  = nd[c];
        end
    endtask

    task automatic step(input bit s, input bit r);
        set_async = s;
        reset_async = r;
        @(posedge clk);
        model_edge(s, r);
        #1;
        check("S", S, 32'(m_left > 0 && m_is_set));
        check("R", R, 32'(m_left > 0 && !m_is_set));
        check("set_db", set_db, 32'(m_db[0]));
        check("reset_db", reset_db, 32'(m_db[1]));
        check("busy", busy, 32'(m_left > 0 || m_hold));
        check("conflict", conflict, 32'(m_conf));
        check("s_and_r", S & R, 0);
        s_cnt += int'(S);
        r_cnt += int'(R);
        c_cnt += int'(conflict);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_async = 1'b0;
        reset_async = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_S", S, 0);
        check("rst_R", R, 0);
        check("rst_set_db", set_db, 0);
        check("rst_reset_db", reset_db, 0);
        check("rst_busy", busy, 0);
        check("rst_conflict", conflict, 0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        s_cnt = 0; r_cnt = 0; first_s = -1;
        for (int i = 1; i <= 20; i++) begin
            step(1, 0);
            if (S && first_s < 0) first_s = i;
        end
        check("t2_latency_ok", 32'(first_s >= SYNC + DEB + 1 && first_s <= SYNC + DEB + 2), 1);
        repeat (10) step(0, 0);
        check("t2_S_len", s_cnt, PL);
        check("t2_no_R", r_cnt, 0);
        s_cnt = 0; r_cnt = 0;
        repeat (20) step(0, 1);
        repeat (10) step(0, 0);
        check("t2_R_len", r_cnt, PL);
        check("t2_no_S", s_cnt, 0);

        s_cnt = 0;
        repeat (3) step(1, 0);
        repeat (10) step(0, 0);
        check("t3_glitch_S", s_cnt, 0);

        s_cnt = 0;
        for (int i = 0; i < 10; i++) step(i % 2 == 0, 0);
        repeat (20) step(1, 0);
        repeat (15) step(0, 0);
        check("t4_bounce_S", s_cnt, PL);

        s_cnt = 0; r_cnt = 0; c_cnt = 0;
        repeat (15) step(1, 1);
        repeat (15) step(0, 0);
        check("t5_conflict", c_cnt, 1);
        check("t5_S", s_cnt, 0);
        check("t5_R", r_cnt, 0);
        repeat (20) step(0, 1);
        repeat (10) step(0, 0);
        check("t5_later_R", r_cnt, PL);

        s_cnt = 0; r_cnt = 0;
        step(1, 0);
        repeat (20) step(1, 1);
        repeat (15) step(0, 0);
        check("t6_S", s_cnt, PL);
        check("t6_no_R", r_cnt, 0);

        for (int i = 0; i < 20 && !S; i++) step(1, 0);
        check("t6_S_seen", S, 1);
        #3;
        rst = 1'b1;
        #1;
        check("t6_async_S", S, 0);
        check("t6_async_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (12) step(0, 0);

        repeat (250) begin
            rs = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 10)) step(rs, rr);
        end
        repeat (15) step(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
